signal_sync_multi: RTL and testbench

Parametrised multi-channel successor of the single-bit synchroniser. Brings `CHANNELS` asynchronous inputs (I2S `bclk`/`lrclk`, external buttons, mode pins) into the `clk_i` domain. Each channel passes through a configurable-depth flop chain and a glitch filter that accepts a new level only after it has been stable for `FILTER_CYCLES` clocks. Per channel, the block reports the filtered level, registered edge pulses, and a sticky edge flag with an acknowledge handshake.

---
 rtl/signal_sync_pkg.sv | 17 +
 rtl/signal_sync_ch.sv | 77 +++++++
 rtl/signal_sync_multi.sv | 45 ++++
 tb/tb_signal_sync_multi.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/signal_sync_pkg.sv
// Shared constants and helpers for clock-domain-crossing blocks.
package signal_sync_pkg;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned FILTER_CYCLES_DEF = 4;

  // Number of bits needed to hold values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/signal_sync_ch.sv
// One synchroniser channel: flop chain, glitch filter, edge pulses and sticky flag.
module signal_sync_ch
  import signal_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  input  logic ack,
  output logic level,
  output logic stable,
  output logic pulse,
  output logic rise,
  output logic fall,
  output logic flag
);

  localparam int unsigned CW = clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] chain;
  logic [CW-1:0]          cnt;
  logic                   sync_s;
  logic                   accept;

  assign sync_s = chain[SYNC_STAGES-1];

  // Metastability chain into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], async_in};
  end

  // A new level is accepted on the cycle its stability count completes.
  always_comb begin
    accept = 1'b0;
    if ((sync_s != level) && (cnt == CNT_LAST)) accept = 1'b1;
  end

  // Filter counter, accepted level and registered edge pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync_s == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync_s;
        cnt   <= '0;
        pulse <= 1'b1;
        rise  <= sync_s;
        fall  <= ~sync_s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Sticky edge flag; a new edge wins over a simultaneous acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n)      flag <= 1'b0;
    else if (accept) flag <= 1'b1;
    else if (ack)    flag <= 1'b0;
  end

  assign stable = (sync_s == level);

endmodule

// File: rtl/signal_sync_multi.sv
// Multi-channel synchroniser with glitch filtering and edge reporting.
module signal_sync_multi
  import signal_sync_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CHANNELS-1:0] signal_i,
  output logic [CHANNELS-1:0] signal_o,
  output logic [CHANNELS-1:0] valid_o,
  output logic [CHANNELS-1:0] edge_o,
  output logic [CHANNELS-1:0] posedge_o,
  output logic [CHANNELS-1:0] negedge_o,
  output logic [CHANNELS-1:0] flag_o,
  input  logic [CHANNELS-1:0] ack_i,
  output logic                any_edge_o
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    signal_sync_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_ch (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .async_in(signal_i[c]),
      .ack     (ack_i[c]),
      .level   (signal_o[c]),
      .stable  (valid_o[c]),
      .pulse   (edge_o[c]),
      .rise    (posedge_o[c]),
      .fall    (negedge_o[c]),
      .flag    (flag_o[c])
    );
  end

  // Summary of all channel pulses.
  always_comb begin
    any_edge_o = |edge_o;
  end

endmodule

// File: tb/tb_signal_sync_multi.sv
// Scoreboard bench: stimulus pushes expected edge events, monitors pop and compare.
module tb_signal_sync_multi;

  typedef struct {
    int unsigned cyc;
    int unsigned ch;
    logic        rise;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] sig, sig_o, valid, edg, pos, neg, flag, ack;
  logic       any;
  logic       sig_p, sig_o_p, valid_p, edg_p, pos_p, neg_p, flag_p, ack_p, any_p;

  int unsigned cyc = 0;
  int unsigned nchecks = 0;
  int unsigned nfail = 0;
  ev_t q[$];
  ev_t q_p[$];

  signal_sync_multi dut (
    .clk_i(clk), .rst_ni(rst_n), .signal_i(sig), .signal_o(sig_o), .valid_o(valid),
    .edge_o(edg), .posedge_o(pos), .negedge_o(neg), .flag_o(flag), .ack_i(ack),
    .any_edge_o(any)
  );

  signal_sync_multi #(.CHANNELS(1), .SYNC_STAGES(3), .FILTER_CYCLES(1)) dut_p (
    .clk_i(clk), .rst_ni(rst_n), .signal_i(sig_p), .signal_o(sig_o_p), .valid_o(valid_p),
    .edge_o(edg_p), .posedge_o(pos_p), .negedge_o(neg_p), .flag_o(flag_p), .ack_i(ack_p),
    .any_edge_o(any_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned at, input int unsigned ch, input logic rise);
    ev_t e;
    e.cyc = at; e.ch = ch; e.rise = rise;
    q.push_back(e);
  endtask

  task automatic push_p(input int unsigned at, input logic rise);
    ev_t e;
    e.cyc = at; e.ch = 0; e.rise = rise;
    q_p.push_back(e);
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor for the default-parameter instance.
  always @(negedge clk) begin
    ev_t e;
    if (q.size() != 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("missing_edge_ch", cyc, e.cyc);
    end
    for (int c = 0; c < 4; c++) begin
      if (edg[c]) begin
        if (q.size() == 0) begin
          check("unexpected_edge_ch", 32'(c), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("edge_cycle", cyc, e.cyc);
          check("edge_channel", 32'(c), e.ch);
          check("posedge", 32'(pos[c]), 32'(e.rise));
          check("negedge", 32'(neg[c]), 32'(!e.rise));
          check("any_edge", 32'(any), 32'd1);
        end
      end
    end
  end

  // Monitor for the swept-parameter instance.
  always @(negedge clk) begin
    ev_t e;
    if (q_p.size() != 0 && q_p[0].cyc < cyc) begin
      e = q_p.pop_front();
      check("p_missing_edge", cyc, e.cyc);
    end
    if (edg_p) begin
      if (q_p.size() == 0) begin
        check("p_unexpected_edge", 32'd1, 32'd0);
      end else begin
        e = q_p.pop_front();
        check("p_edge_cycle", cyc, e.cyc);
        check("p_posedge", 32'(pos_p), 32'(e.rise));
        check("p_negedge", 32'(neg_p), 32'(!e.rise));
        check("p_any_edge", 32'(any_p), 32'd1);
      end
    end
  end

  initial begin
    int unsigned k, r;
    rst_n = 1'b0; sig = 4'hF; ack = 4'h0; sig_p = 1'b0; ack_p = 1'b0;

    // Reset with inputs held high.
    repeat (3) @(negedge clk);
    check("rst_signal", 32'(sig_o), 32'h0);
    check("rst_edge", 32'(edg), 32'h0);
    check("rst_pos_neg", 32'({pos, neg}), 32'h0);
    check("rst_flag", 32'(flag), 32'h0);
    check("rst_any", 32'(any), 32'h0);
    check("rst_valid", 32'(valid), 32'hF);
    check("rst_p_signal", 32'(sig_o_p), 32'h0);
    rst_n = 1'b1;
    k = cyc;
    for (int unsigned c = 0; c < 4; c++) push(k + 6, c, 1'b1);
    wait_cyc(k + 5);
    check("rel_signal_early", 32'(sig_o), 32'h0);
    wait_cyc(k + 6);
    check("rel_signal", 32'(sig_o), 32'hF);
    check("rel_flag", 32'(flag), 32'hF);
    ack = 4'hF; @(negedge clk); ack = 4'h0;
    check("ack_clear_all", 32'(flag), 32'h0);

    // Drop channels 1..3.
    sig = 4'h1;
    k = cyc;
    for (int unsigned c = 1; c < 4; c++) push(k + 6, c, 1'b0);
    wait_cyc(k + 6);
    check("fall_signal", 32'(sig_o), 32'h1);
    check("fall_flag", 32'(flag), 32'hE);
    ack = 4'hF; @(negedge clk); ack = 4'h0;

    // Three-cycle glitch on ch0 is rejected.
    sig[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 3) sig[0] = 1'b1;
      check("glitch_valid0", 32'(valid[0]), 32'((i >= 2 && i <= 4) ? 0 : 1));
      check("glitch_signal0", 32'(sig_o[0]), 32'd1);
      check("glitch_flag0", 32'(flag[0]), 32'd0);
    end

    // Clean toggle on ch1.
    sig[1] = 1'b1;
    k = cyc;
    push(k + 6, 1, 1'b1);
    wait_cyc(k + 10);
    check("toggle_high", 32'(sig_o[1]), 32'd1);
    sig[1] = 1'b0;
    k = cyc;
    push(k + 6, 1, 1'b0);
    wait_cyc(k + 8);
    check("toggle_low", 32'(sig_o[1]), 32'd0);
    ack = 4'hF; @(negedge clk); ack = 4'h0;

    // Acknowledge collides with an accepted edge on ch2.
    sig[2] = 1'b1;
    k = cyc;
    push(k + 6, 2, 1'b1);
    wait_cyc(k + 5);
    ack[2] = 1'b1;
    wait_cyc(k + 6);
    ack[2] = 1'b0;
    check("collide_flag2", 32'(flag[2]), 32'd1);
    @(negedge clk);
    check("collide_flag2_hold", 32'(flag[2]), 32'd1);
    ack[2] = 1'b1;
    @(negedge clk);
    ack[2] = 1'b0;
    check("ack_flag2", 32'(flag[2]), 32'd0);

    // Reset while ch3 is mid-count.
    sig[3] = 1'b1;
    k = cyc;
    wait_cyc(k + 4);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_signal", 32'(sig_o), 32'h0);
    check("midrst_edge", 32'(edg), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    push(r + 6, 0, 1'b1);
    push(r + 6, 2, 1'b1);
    push(r + 6, 3, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst_no_pulse", 32'(edg), 32'h0);
    end
    wait_cyc(r + 6);
    check("midrst_signal_after", 32'(sig_o), 32'hD);

    // Swept parameters: 3 stages, filter of 1.
    sig_p = 1'b1;
    k = cyc;
    push_p(k + 4, 1'b1);
    @(negedge clk);
    sig_p = 1'b0;
    push_p(k + 5, 1'b0);
    wait_cyc(k + 4);
    check("p_signal_high", 32'(sig_o_p), 32'd1);
    wait_cyc(k + 5);
    check("p_signal_low", 32'(sig_o_p), 32'd0);
    sig_p = 1'b1;
    k = cyc;
    push_p(k + 4, 1'b1);
    wait_cyc(k + 3);
    sig_p = 1'b0;
    push_p(k + 7, 1'b0);
    wait_cyc(k + 7);
    check("p_flag", 32'(flag_p), 32'd1);

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    check("p_queue_drained", 32'(q_p.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
